// File: rtl/dbus_pkg.sv
// Shared definitions for the M-stage data bus: cycle-size codes, responder
// FSM states and the byte-lane helpers used by both the responder and its RAM.
package dbus_pkg;

    localparam logic [3:0] CYC_NONE  = 4'd0;
    localparam logic [3:0] CYC_BYTE  = 4'd1;
    localparam logic [3:0] CYC_HALF  = 4'd2;
    localparam logic [3:0] CYC_WORD  = 4'd4;
    localparam logic [3:0] CYC_DWORD = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    function automatic logic is_legal_size(input logic [3:0] size);
        return size inside {CYC_BYTE, CYC_HALF, CYC_WORD, CYC_DWORD};
    endfunction

    // Byte-lane enables for an access of 'size' bytes starting at lane 'off'.
    function automatic logic [7:0] byte_en(input logic [3:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            CYC_BYTE:  m = 8'h01;
            CYC_HALF:  m = 8'h03;
            CYC_WORD:  m = 8'h0F;
            CYC_DWORD: m = 8'hFF;
            default:   m = 8'h00;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(input logic [3:0] size, input logic [2:0] off);
        return (off & 3'(size - 4'd1)) != 3'd0;
    endfunction

    // Bit mask keeping the low 'size' bytes of a right-justified value.
    function automatic logic [63:0] lane_mask(input logic [3:0] size);
        logic [7:0]  be;
        logic [63:0] m;
        be = byte_en(size, 3'd0);
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-bus bundle between the M stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic [3:0]  s_cyc_i;
    logic [63:0] s_adr_i;
    logic        s_we_i;
    logic [63:0] s_dat_i;
    logic [63:0] s_dat_o;
    logic        s_ack_o;
    logic        s_err_o;

    modport master (
        output s_cyc_i, s_adr_i, s_we_i, s_dat_i,
        input  s_dat_o, s_ack_o, s_err_o
    );

    modport slave (
        input  s_cyc_i, s_adr_i, s_we_i, s_dat_i,
        output s_dat_o, s_ack_o, s_err_o
    );
endinterface

// File: rtl/dmem_responder_byte_ram.sv
// Doubleword RAM with eight byte write enables and a registered read port.
module dmem_byte_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [63:0]          rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_be,
    input  logic [63:0]          wr_data
);

    logic [63:0] mem [2**ADDR_BITS];

    // NOTE: no reset here on purpose; a RAM array cannot be cleared in one
    // cycle, and its contents must survive a reset of the surrounding logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the M-stage data bus: captures a sized request, waits a fixed
// number of cycles, performs the byte-lane access and pulses acknowledge.
module dmem_responder
    import dbus_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    dmem_responder_if.slave  bus
);

    localparam int         IDX_HI  = ADDR_BITS + 2;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            capture, enter_ack;

    logic [3:0]      cyc_q;
    logic [IDX_HI:0] adr_q;
    logic            we_q;
    logic [63:0]     dat_q;
    logic            err_q;
    logic            ack_q, ack_err_q;

    logic            in_err;
    logic            in_idle;
    logic [3:0]      cur_cyc;
    logic [IDX_HI:0] cur_adr;
    logic            cur_we, cur_err;
    logic [63:0]     cur_dat;
    logic [63:0]     rd_data;

    // All faults are decided from the request as presented at capture time.
    assign in_err = !is_legal_size(bus.s_cyc_i)
                  || misaligned(bus.s_cyc_i, bus.s_adr_i[2:0])
                  || (bus.s_adr_i[63:IDX_HI+1] != '0);

    // With zero wait states the RAM write lands on the capture edge itself,
    // so the write port must see the live request rather than the registers.
    assign in_idle = (state_q == ST_IDLE);
    assign cur_cyc = in_idle ? bus.s_cyc_i             : cyc_q;
    assign cur_adr = in_idle ? bus.s_adr_i[IDX_HI:0]   : adr_q;
    assign cur_we  = in_idle ? bus.s_we_i              : we_q;
    assign cur_dat = in_idle ? bus.s_dat_i             : dat_q;
    assign cur_err = in_idle ? in_err                  : err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.s_cyc_i != CYC_NONE) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.s_cyc_i == CYC_NONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d   = ST_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register below uses <= so all of them update from the same
    // pre-edge values; a blocking assignment would leak new values downstream.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            ack_q     <= 1'b0;
            ack_err_q <= 1'b0;
            cyc_q     <= CYC_NONE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= enter_ack;
            ack_err_q <= enter_ack & cur_err;
            if (capture) begin
                cyc_q <= bus.s_cyc_i;
                adr_q <= bus.s_adr_i[IDX_HI:0];
                we_q  <= bus.s_we_i;
                dat_q <= bus.s_dat_i;
                err_q <= in_err;
            end
        end
    end

    dmem_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (clk_i),
        .rd_en   (capture),
        .rd_addr (bus.s_adr_i[IDX_HI:3]),
        .rd_data (rd_data),
        .wr_en   (enter_ack & cur_we & ~cur_err),
        .wr_addr (cur_adr[IDX_HI:3]),
        .wr_be   (byte_en(cur_cyc, cur_adr[2:0])),
        .wr_data (cur_dat << {cur_adr[2:0], 3'b000})
    );

    assign bus.s_ack_o = ack_q;
    assign bus.s_err_o = ack_err_q;
    assign bus.s_dat_o = (ack_q && !ack_err_q && !we_q)
                       ? ((rd_data >> {adr_q[2:0], 3'b000}) & lane_mask(cyc_q))
                       : 64'd0;

endmodule
